// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
//   - op_e     : operation encodings carried on the op input
//   - state_e  : sequencing FSM states
//   - HILO_WR_*: bit positions inside hilo_wr (MTHI / MTLO requests)
//   - helpers  : op classification used at launch and in fixup
package mdu_pkg;

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CALC  = 2'd1,
      ST_FIXUP = 2'd2
   } state_e;

   localparam int HILO_WR_HI = 1;
   localparam int HILO_WR_LO = 0;

   function automatic logic op_is_div(input op_e op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

   function automatic logic op_is_signed(input op_e op);
      return (op == OP_MULT) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: request/result bundle of the multiply/divide unit.
//   master (requester) drives : start, op, operand_a, operand_b, hilo_wr, hilo_wdata
//   slave  (unit) drives      : busy, done, div_zero, hi, lo
interface mult_div_unit_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] operand_a;
   logic [WIDTH-1:0] operand_b;
   logic [1:0]       hilo_wr;
   logic [WIDTH-1:0] hilo_wdata;
   logic             busy;
   logic             done;
   logic             div_zero;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, operand_a, operand_b, hilo_wr, hilo_wdata,
      input  busy, done, div_zero, hi, lo
   );

   modport slave (
      input  start, op, operand_a, operand_b, hilo_wr, hilo_wdata,
      output busy, done, div_zero, hi, lo
   );
endinterface

// File: rtl/mdu_iter_core.sv
// mdu_iter_core: one iteration of the unsigned datapath (combinational).
//   is_div          : 1 = restoring-divide step, 0 = shift-add multiply step
//   acc_hi / acc_lo : current accumulator pair
//   operand         : multiplicand or divisor magnitude
//   nxt_hi / nxt_lo : accumulator pair after this step
// Multiply: {hi,lo} starts as {0, multiplier}; after WIDTH steps it holds the product.
// Divide  : {hi,lo} starts as {0, dividend}; after WIDTH steps hi = remainder, lo = quotient.
// Macro MULT_DIV_UNIT_DIV_EN compiles in the divide step; without it only multiply exists.
module mdu_iter_core #(
   parameter int WIDTH = 32
) (
   input  logic             is_div,
   input  logic [WIDTH-1:0] acc_hi,
   input  logic [WIDTH-1:0] acc_lo,
   input  logic [WIDTH-1:0] operand,
   output logic [WIDTH-1:0] nxt_hi,
   output logic [WIDTH-1:0] nxt_lo
);
   logic [WIDTH:0] add_sum;
   logic [WIDTH:0] add_keep;

   assign add_sum  = {1'b0, acc_hi} + {1'b0, operand};
   assign add_keep = acc_lo[0] ? add_sum : {1'b0, acc_hi};

`ifdef MULT_DIV_UNIT_DIV_EN
   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;
   logic           fits;

   assign shifted = {acc_hi, acc_lo[WIDTH-1]};
   assign diff    = shifted - {1'b0, operand};
   // Partial remainder stays below the divisor, so shifted < 2*divisor and the
   // top bit of diff is a valid borrow. With a zero divisor hi only ever holds
   // leading dividend bits, so shifted never reaches bit WIDTH either.
   assign fits    = ~diff[WIDTH];

   always_comb begin
      if (is_div) begin
         nxt_hi = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
         nxt_lo = {acc_lo[WIDTH-2:0], fits};
      end else begin
         nxt_hi = add_keep[WIDTH:1];
         nxt_lo = {add_keep[0], acc_lo[WIDTH-1:1]};
      end
   end
`else
   logic unused_is_div;
   assign unused_is_div = is_div;
   assign nxt_hi = add_keep[WIDTH:1];
   assign nxt_lo = {add_keep[0], acc_lo[WIDTH-1:1]};
`endif

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MULT/MULTU/DIV/DIVU unit with HI/LO result registers.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : mult_div_unit_if.slave (start/op/operands/hilo_wr in; busy/done/div_zero/hi/lo out)
// Operands are turned into magnitudes at launch, iterated WIDTH times in
// mdu_iter_core, and sign-corrected in FIXUP before landing in HI/LO.
// Macro MULT_DIV_UNIT_DIV_EN enables the divider; when undefined a DIV/DIVU
// start only produces a done pulse and leaves HI/LO untouched.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting; accepts start, or MTHI/MTLO when start is low
// ST_CALC  | one datapath iteration per cycle, WIDTH cycles
// ST_FIXUP | sign correction, HI/LO update, done pulse
module mult_div_unit
   import mdu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic           clk,
   input  logic           rst_n,
   mult_div_unit_if.slave bus
);
   localparam int CW = $clog2(WIDTH);

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   op_e              op_q, op_d;
   logic             neg_res_q, neg_res_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
   logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             done_q, done_d;
   logic             dz_q, dz_d;

   op_e              op_in;
   logic             signed_in;
   logic             a_neg, b_neg;
   logic [WIDTH-1:0] mag_a, mag_b;
   logic [WIDTH-1:0] step_hi, step_lo;
   logic [2*WIDTH-1:0] prod;
   logic             div_nop;

`ifdef MULT_DIV_UNIT_DIV_EN
   logic             neg_rem_q, neg_rem_d;
   logic [WIDTH-1:0] quo, rem;
   assign div_nop = 1'b0;
`else
   assign div_nop = op_is_div(op_in);
`endif

   assign op_in     = op_e'(bus.op);
   assign signed_in = op_is_signed(op_in);
   assign a_neg     = signed_in & bus.operand_a[WIDTH-1];
   assign b_neg     = signed_in & bus.operand_b[WIDTH-1];
   assign mag_a     = a_neg ? -bus.operand_a : bus.operand_a;
   assign mag_b     = b_neg ? -bus.operand_b : bus.operand_b;

   mdu_iter_core #(.WIDTH(WIDTH)) u_core (
      .is_div  (op_is_div(op_q)),
      .acc_hi  (acc_hi_q),
      .acc_lo  (acc_lo_q),
      .operand (b_q),
      .nxt_hi  (step_hi),
      .nxt_lo  (step_lo)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      op_d      = op_q;
      neg_res_d = neg_res_q;
      b_d       = b_q;
      acc_hi_d  = acc_hi_q;
      acc_lo_d  = acc_lo_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      done_d    = 1'b0;
      dz_d      = dz_q;
      prod      = '0;
`ifdef MULT_DIV_UNIT_DIV_EN
      neg_rem_d = neg_rem_q;
      quo       = '0;
      rem       = '0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               dz_d = 1'b0;
               if (div_nop) begin
                  done_d = 1'b1;
               end else begin
                  state_d   = ST_CALC;
                  cnt_d     = CW'(WIDTH - 1);
                  op_d      = op_in;
                  neg_res_d = a_neg ^ b_neg;
`ifdef MULT_DIV_UNIT_DIV_EN
                  neg_rem_d = a_neg;
`endif
                  b_d       = mag_b;
                  acc_hi_d  = '0;
                  acc_lo_d  = mag_a;
               end
            end else begin
               if (bus.hilo_wr[HILO_WR_HI]) hi_d = bus.hilo_wdata;
               if (bus.hilo_wr[HILO_WR_LO]) lo_d = bus.hilo_wdata;
            end
         end
         ST_CALC: begin
            acc_hi_d = step_hi;
            acc_lo_d = step_lo;
            if (cnt_q == '0) state_d = ST_FIXUP;
            else             cnt_d   = cnt_q - 1'b1;
         end
         ST_FIXUP: begin
            prod = {acc_hi_q, acc_lo_q};
            if (neg_res_q) prod = -prod;
            hi_d = prod[2*WIDTH-1:WIDTH];
            lo_d = prod[WIDTH-1:0];
`ifdef MULT_DIV_UNIT_DIV_EN
            if (op_is_div(op_q)) begin
               quo = neg_res_q ? -acc_lo_q : acc_lo_q;
               rem = neg_rem_q ? -acc_hi_q : acc_hi_q;
               // A zero divisor already leaves the dividend in hi; only the
               // quotient needs forcing to all ones.
               if (b_q == '0) begin
                  quo  = '1;
                  dz_d = 1'b1;
               end
               hi_d = rem;
               lo_d = quo;
            end
`endif
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         op_q      <= OP_MULT;
         neg_res_q <= 1'b0;
         b_q       <= '0;
         acc_hi_q  <= '0;
         acc_lo_q  <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         done_q    <= 1'b0;
         dz_q      <= 1'b0;
`ifdef MULT_DIV_UNIT_DIV_EN
         neg_rem_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         op_q      <= op_d;
         neg_res_q <= neg_res_d;
         b_q       <= b_d;
         acc_hi_q  <= acc_hi_d;
         acc_lo_q  <= acc_lo_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         done_q    <= done_d;
         dz_q      <= dz_d;
`ifdef MULT_DIV_UNIT_DIV_EN
         neg_rem_q <= neg_rem_d;
`endif
      end
   end

   assign bus.busy     = (state_q != ST_IDLE);
   assign bus.done     = done_q;
   assign bus.div_zero = dz_q;
   assign bus.hi       = hi_q;
   assign bus.lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed-vector bench for mult_div_unit (WIDTH = 32).
// Follows MULT_DIV_UNIT_DIV_EN: with it, divide results are checked; without
// it, DIV/DIVU must only pulse done and leave HI/LO alone.
module tb_mult_div_unit;
   import mdu_pkg::*;

   localparam int WIDTH = 32;
`ifdef MULT_DIV_UNIT_DIV_EN
   localparam bit DIV_EN = 1'b1;
`else
   localparam bit DIV_EN = 1'b0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   mult_div_unit_if #(.WIDTH(WIDTH)) bus ();

   mult_div_unit #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   logic [31:0] r_hi, r_lo, m_hi, m_lo;
   logic        busy1, dz1;
   int          lat;
   int          done_cnt;

   // Launch one op, scramble inputs after acceptance, wait for done (bounded).
   // mid = 1: re-pulse start while busy; mid = 2: attempt MTHI/MTLO while busy.
   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int mid);
      bus.op        = op;
      bus.operand_a = a;
      bus.operand_b = b;
      bus.start     = 1'b1;
      @(posedge clk); #1;
      bus.start     = 1'b0;
      bus.op        = ~op;
      bus.operand_a = a ^ 32'h5A5A_A5A5;
      bus.operand_b = ~b;
      busy1 = bus.busy;
      dz1   = bus.div_zero;
      m_hi  = bus.hi;
      m_lo  = bus.lo;
      lat   = 0;
      while (!bus.done && lat < 60) begin
         @(posedge clk); #1;
         lat++;
         bus.start      = (mid == 1 && lat == 10);
         bus.hilo_wr    = (mid == 2 && lat == 10) ? 2'b11 : 2'b00;
         bus.hilo_wdata = 32'hDEAD_BEEF;
         if (lat == 12) begin
            m_hi = bus.hi;
            m_lo = bus.lo;
         end
      end
      r_hi = bus.hi;
      r_lo = bus.lo;
      bus.start   = 1'b0;
      bus.hilo_wr = 2'b00;
   endtask

   task automatic op_check(input string tag, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_hi,
                           input logic [31:0] exp_lo, input int mid);
      logic runs;
      runs = !(op[1] && !DIV_EN);
      run_op(op, a, b, mid);
      chk({tag, "_lat"},    64'(lat),   runs ? 64'd33 : 64'd0);
      chk({tag, "_busy"},   64'(busy1), 64'(runs));
      chk({tag, "_dz_clr"}, 64'(dz1),   64'd0);
      chk({tag, "_hi"},     64'(r_hi),  64'(exp_hi));
      chk({tag, "_lo"},     64'(r_lo),  64'(exp_lo));
      @(posedge clk); #1;
      chk({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
      chk({tag, "_hold"}, {bus.hi, bus.lo}, {exp_hi, exp_lo});
   endtask

   initial begin
      bus.start      = 1'b0;
      bus.op         = 2'b00;
      bus.operand_a  = '0;
      bus.operand_b  = '0;
      bus.hilo_wr    = 2'b00;
      bus.hilo_wdata = '0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_hi",   64'(bus.hi),       64'd0);
      chk("rst_lo",   64'(bus.lo),       64'd0);
      chk("rst_busy", 64'(bus.busy),     64'd0);
      chk("rst_done", 64'(bus.done),     64'd0);
      chk("rst_dz",   64'(bus.div_zero), 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      op_check("multu_23x67",   OP_MULTU, 32'd23,        32'd67,        32'h0000_0000, 32'd1541,      0);
      op_check("mult_m1x2",     OP_MULT,  32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFE, 1);
      op_check("mult_m3x5",     OP_MULT,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 0);
      op_check("mult_m4xm6",    OP_MULT,  32'hFFFF_FFFC, 32'hFFFF_FFFA, 32'h0000_0000, 32'd24,        0);
      op_check("multu_max",     OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0);
      op_check("mult_minxmin",  OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 0);

      bus.hilo_wr = 2'b10; bus.hilo_wdata = 32'h1234_5678;
      @(posedge clk); #1;
      bus.hilo_wr = 2'b00;
      chk("mthi_hi", 64'(bus.hi), 64'h1234_5678);
      chk("mthi_lo", 64'(bus.lo), 64'h0);
      bus.hilo_wr = 2'b01; bus.hilo_wdata = 32'h9ABC_DEF0;
      @(posedge clk); #1;
      bus.hilo_wr = 2'b00;
      chk("mtlo_lo", 64'(bus.lo), 64'h9ABC_DEF0);
      chk("mtlo_hi", 64'(bus.hi), 64'h1234_5678);

      op_check("multu_wrbusy", OP_MULTU, 32'd1000, 32'd1000, 32'h0, 32'd1000000, 2);
      chk("wrbusy_mid", {m_hi, m_lo}, {32'h1234_5678, 32'h9ABC_DEF0});

      bus.hilo_wr = 2'b11; bus.hilo_wdata = 32'h0000_0055;
      op_check("start_wins", OP_MULTU, 32'd6, 32'd7, 32'h0, 32'd42, 0);
      chk("start_wins_mid", {m_hi, m_lo}, {32'h0, 32'd1000000});

`ifdef MULT_DIV_UNIT_DIV_EN
      op_check("div_m7_2",   OP_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
      op_check("div_ovf",    OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 0);
      op_check("div_7_m2",   OP_DIV,  32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 0);
      op_check("divu_100_7", OP_DIVU, 32'd100,       32'd7,         32'd2,         32'd14,        0);
      chk("dz_before", 64'(bus.div_zero), 64'd0);
      op_check("divu_72_0",  OP_DIVU, 32'd72,        32'd0,         32'd72,        32'hFFFF_FFFF, 0);
      chk("dz_set", 64'(bus.div_zero), 64'd1);
      op_check("div_m5_0",   OP_DIV,  32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 0);
      chk("dz_set2", 64'(bus.div_zero), 64'd1);
      op_check("dz_clear",   OP_MULTU, 32'd2,        32'd3,         32'h0,         32'd6,         0);
      chk("dz_cleared", 64'(bus.div_zero), 64'd0);
`else
      op_check("divu_nodiv", OP_DIVU, 32'd72,        32'd0,         32'h0,         32'd42,        0);
      chk("dz_nodiv", 64'(bus.div_zero), 64'd0);
      op_check("div_nodiv",  OP_DIV,  32'hFFFF_FFF9, 32'd2,         32'h0,         32'd42,        0);
      chk("dz_nodiv2", 64'(bus.div_zero), 64'd0);
`endif

      // Abort an in-flight op with reset ten cycles in.
      bus.op        = DIV_EN ? OP_DIVU : OP_MULTU;
      bus.operand_a = 32'd1000;
      bus.operand_b = 32'd3;
      bus.start     = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      chk("abort_busy_pre", 64'(bus.busy), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("abort_hi",   64'(bus.hi),   64'd0);
      chk("abort_lo",   64'(bus.lo),   64'd0);
      chk("abort_busy", 64'(bus.busy), 64'd0);
      chk("abort_done", 64'(bus.done), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      done_cnt = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (bus.done) done_cnt++;
      end
      chk("abort_no_done", 64'(done_cnt), 64'd0);
      chk("abort_idle",    64'(bus.busy), 64'd0);
      op_check("multu_3x5", OP_MULTU, 32'd3, 32'd5, 32'h0, 32'd15, 0);

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
